// File: rtl/rx_frame_pkg.sv
// Shared definitions for the serial frame receiver: state encoding, default
// header pattern and the bit-counter width helper.
package rx_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } state_t;

  localparam logic [3:0] HDR_PAT_DEF = 4'b1010;

  // Wide enough to count up to the longer of the header and data fields.
  function automatic int cnt_w(input int hdr_w, input int data_w);
    return $clog2(((hdr_w > data_w) ? hdr_w : data_w) + 1);
  endfunction

endpackage

// File: rtl/rx_out_reg.sv
// One-deep output holding register with vld/rdy handshake; flags a completed
// word that arrives while an unconsumed word is still held.
module rx_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              rdy,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              ovr_err
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      ovr_err <= 1'b0;
      if (load) begin
        // A word consumed on this same edge frees the slot for the new one.
        if (dout_vld && !rdy) begin
          ovr_err <= 1'b1;
        end else begin
          dout     <= word;
          dout_vld <= 1'b1;
        end
      end else if (dout_vld && rdy) begin
        dout_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rx_frame_deser.sv
// Serial frame deserializer: header check, MSB-first payload, optional even
// parity, inter-bit timeout, and a re-arm pulse for the upstream bit sync FSM.
module rx_frame_deser
  import rx_frame_pkg::*;
#(
  parameter int               DATA_W  = 8,
  parameter int               HDR_W   = 4,
  parameter logic [HDR_W-1:0] HDR_PAT = HDR_PAT_DEF,
  parameter int               PAR_EN  = 1,
  parameter int               TMO_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sh_en,
  input  logic              din,
  input  logic              rdy,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              hdr_err,
  output logic              par_err,
  output logic              ovr_err,
  output logic              tmo_err,
  output logic              fsm_rst,
  output logic              busy
);

  localparam int SR_W  = (DATA_W > HDR_W) ? DATA_W : HDR_W;
  localparam int CNT_W = cnt_w(HDR_W, DATA_W);
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  // The first header bit is taken in IDLE, so HDR counts one bit fewer.
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 2);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYC - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [TMO_W-1:0]    tmo;
  logic [SR_W-1:0]     sr;
  logic                hdr_ok;
  logic                par_ok;
  logic                load;
  logic [DATA_W-1:0]   word;

  assign hdr_ok = ({sr[HDR_W-2:0], din} == HDR_PAT);
  assign par_ok = (din == ^sr[DATA_W-1:0]);
  assign load   = sh_en && (((state == DATA) && (cnt == DATA_LAST) && (PAR_EN == 0)) ||
                            ((state == PAR) && par_ok));
  // In PAR the payload already sits in the shift register; otherwise the
  // incoming bit is the payload LSB.
  assign word   = (state == PAR) ? sr[DATA_W-1:0] : {sr[DATA_W-2:0], din};
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      tmo     <= '0;
      sr      <= '0;
      hdr_err <= 1'b0;
      par_err <= 1'b0;
      tmo_err <= 1'b0;
      fsm_rst <= 1'b0;
    end else begin
      hdr_err <= 1'b0;
      par_err <= 1'b0;
      tmo_err <= 1'b0;
      fsm_rst <= 1'b0;
      if (sh_en) sr <= {sr[SR_W-2:0], din};

      if (state == IDLE) begin
        cnt <= '0;
        tmo <= '0;
        if (sh_en) state <= HDR;
      end else if (sh_en) begin
        tmo <= '0;
        cnt <= cnt + CNT_W'(1);
        case (state)
          HDR: begin
            if (cnt == HDR_LAST) begin
              cnt <= '0;
              if (hdr_ok) begin
                state <= DATA;
              end else begin
                hdr_err <= 1'b1;
                fsm_rst <= 1'b1;
                state   <= IDLE;
              end
            end
          end
          DATA: begin
            if (cnt == DATA_LAST) begin
              cnt <= '0;
              if (PAR_EN != 0) begin
                state <= PAR;
              end else begin
                fsm_rst <= 1'b1;
                state   <= IDLE;
              end
            end
          end
          default: begin
            cnt     <= '0;
            fsm_rst <= 1'b1;
            par_err <= !par_ok;
            state   <= IDLE;
          end
        endcase
      end else if (tmo == TMO_LAST) begin
        tmo     <= '0;
        cnt     <= '0;
        tmo_err <= 1'b1;
        fsm_rst <= 1'b1;
        state   <= IDLE;
      end else begin
        tmo <= tmo + TMO_W'(1);
      end
    end
  end

  rx_out_reg #(
    .DATA_W(DATA_W)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .word    (word),
    .rdy     (rdy),
    .dout    (dout),
    .dout_vld(dout_vld),
    .ovr_err (ovr_err)
  );

endmodule
